// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared constants and types for the operand fetch block.
//   MEM_W      - default register / operand width
//   RF_AW_DEF  - default register-file address width (16 registers)
//   ST_*       - 3-bit FSM state encodings, used by state_t
//   tag_t      - identifies which operand an in-flight read belongs to
package operand_fetch_pkg;

    localparam int MEM_W     = 16;
    localparam int RF_AW_DEF = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE_A = 3'd1;
    localparam logic [2:0] ST_ISSUE_B = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ISSUE_A = ST_ISSUE_A,
        ISSUE_B = ST_ISSUE_B,
        DRAIN   = ST_DRAIN,
        OUT     = ST_OUT
    } state_t;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_t;

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles every non-clock signal of the operand fetch block.
//   request  : req_valid, req_ready, rs_a, rs_b, need_b
//   writeback: wb_valid, wb_addr, wb_data
//   reg file : rf_sel, rf_wr, rf_rd, rf_wdata, rf_rdata
//   execute  : op_valid, op_ready, op_a, op_b
// master is the operand fetch block; slave is its surroundings
// (decode, writeback, register file and execute).
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = MEM_W,
    parameter int RF_AW  = RF_AW_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [RF_AW-1:0]  rs_a;
    logic [RF_AW-1:0]  rs_b;
    logic              need_b;
    logic              wb_valid;
    logic [RF_AW-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [RF_AW-1:0]  rf_sel;
    logic              rf_wr;
    logic              rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    modport master (
        input  req_valid, rs_a, rs_b, need_b, wb_valid, wb_addr, wb_data,
               rf_rdata, op_ready,
        output req_ready, rf_sel, rf_wr, rf_rd, rf_wdata, op_valid, op_a, op_b
    );

    modport slave (
        output req_valid, rs_a, rs_b, need_b, wb_valid, wb_addr, wb_data,
               rf_rdata, op_ready,
        input  req_ready, rf_sel, rf_wr, rf_rd, rf_wdata, op_valid, op_a, op_b
    );
endinterface

// File: rtl/of_operand_slot.sv
// of_operand_slot: one operand register plus its forwarded flag.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : new request accepted; zero the operand and the flag
//   fwd_hit   : writeback targets this operand now; load fwd_data, set flag
//   cap       : register-file read data for this operand is on cap_data
//   op, fwd   : operand value and forwarded flag
// Once forwarded, the operand ignores register-file data: that read was
// issued before (or alongside) the newer writeback and is stale.
module of_operand_slot
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = MEM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              fwd_hit,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              cap,
    input  logic [DATA_W-1:0] cap_data,
    output logic [DATA_W-1:0] op,
    output logic              fwd
);

    always_ff @(posedge clk) begin
        if (rst) begin
            op  <= '0;
            fwd <= 1'b0;
        end else if (clear) begin
            op  <= '0;
            fwd <= 1'b0;
        end else if (fwd_hit) begin
            // A forward in the capture cycle beats the returning read data.
            op  <= fwd_data;
            fwd <= 1'b1;
        end else if (cap && !fwd) begin
            op  <= cap_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads up to two source operands over the single
// register-file port, giving writeback writes priority on the port and
// forwarding writeback data into operands that are still being fetched.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand_fetch_if.master (request, writeback, register-file
//              and execute-stage signals)
// Read data returns one cycle after rf_rd; rd_pend/rd_tag remember which
// operand that returning data belongs to.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = MEM_W,
    parameter int RF_AW  = RF_AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.master bus
);

    state_t            state;
    logic [RF_AW-1:0]  rs_a_q;
    logic [RF_AW-1:0]  rs_b_q;
    logic              need_b_q;
    logic              rd_pend;
    tag_t              rd_tag;
    logic              op_valid_q;

    logic              fwd_a;
    logic              fwd_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              accept;
    logic              issue_a;
    logic              issue_b;
    logic              fwd_win;
    logic              fwd_a_hit;
    logic              fwd_b_hit;
    logic              cap_a;
    logic              cap_b;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // A writeback owns the port this cycle; an already-forwarded operand
    // needs no read at all.
    assign issue_a = !rst && !bus.wb_valid && (state == ISSUE_A) && !fwd_a;
    assign issue_b = !rst && !bus.wb_valid && (state == ISSUE_B) && !fwd_b;

    // Operands are frozen once presented in OUT.
    assign fwd_win   = (state == ISSUE_A) || (state == ISSUE_B) || (state == DRAIN);
    assign fwd_a_hit = fwd_win && bus.wb_valid && (bus.wb_addr == rs_a_q);
    assign fwd_b_hit = fwd_win && bus.wb_valid && need_b_q && (bus.wb_addr == rs_b_q);

    assign cap_a = rd_pend && (rd_tag == TAG_A);
    assign cap_b = rd_pend && (rd_tag == TAG_B);

    always_comb begin
        bus.rf_wr    = 1'b0;
        bus.rf_rd    = 1'b0;
        bus.rf_sel   = '0;
        bus.rf_wdata = '0;
        if (!rst) begin
            if (bus.wb_valid) begin
                bus.rf_wr    = 1'b1;
                bus.rf_sel   = bus.wb_addr;
                bus.rf_wdata = bus.wb_data;
            end else if (issue_a) begin
                bus.rf_rd  = 1'b1;
                bus.rf_sel = rs_a_q;
            end else if (issue_b) begin
                bus.rf_rd  = 1'b1;
                bus.rf_sel = rs_b_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            need_b_q   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_tag     <= TAG_A;
            op_valid_q <= 1'b0;
        end else begin
            rd_pend <= issue_a || issue_b;
            if (issue_a) begin
                rd_tag <= TAG_A;
            end else if (issue_b) begin
                rd_tag <= TAG_B;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs_a_q   <= bus.rs_a;
                        rs_b_q   <= bus.rs_b;
                        need_b_q <= bus.need_b;
                        state    <= ISSUE_A;
                    end
                end
                ISSUE_A: begin
                    if (!bus.wb_valid) begin
                        state <= need_b_q ? ISSUE_B : DRAIN;
                    end
                end
                ISSUE_B: begin
                    if (!bus.wb_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state      <= OUT;
                    op_valid_q <= 1'b1;
                end
                OUT: begin
                    if (bus.op_ready) begin
                        state      <= IDLE;
                        op_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    op_valid_q <= 1'b0;
                end
            endcase
        end
    end

    of_operand_slot #(.DATA_W(DATA_W)) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .fwd_hit  (fwd_a_hit),
        .fwd_data (bus.wb_data),
        .cap      (cap_a),
        .cap_data (bus.rf_rdata),
        .op       (op_a),
        .fwd      (fwd_a)
    );

    of_operand_slot #(.DATA_W(DATA_W)) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .fwd_hit  (fwd_b_hit),
        .fwd_data (bus.wb_data),
        .cap      (cap_b),
        .cap_data (bus.rf_rdata),
        .op       (op_b),
        .fwd      (fwd_b)
    );

    assign bus.op_valid = op_valid_q;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;

endmodule
